// File: rtl/sargantana_icache_refill_unit.sv
// ============================================================================
//  Module      : sargantana_icache_refill_unit
//  Description : Icache miss-refill engine. It issues one L2 line request,
//                assembles the response beats into a line buffer, picks a
//                victim way and drives the array write and the checker fill.
//                Optional perf counters: SARGANTANA_ICACHE_REFILL_PERF_EN
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sargantana_icache_refill_unit #(
    parameter int BEAT_WIDTH = 128,
    parameter int LINE_WIDTH = 256,
    parameter int N_WAY      = 4,
    parameter int TAG_W      = 20,
    parameter int IDX_W      = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   miss_i,
    input  logic [TAG_W-1:0]       miss_tag_i,
    input  logic [IDX_W-1:0]       miss_idx_i,
    input  logic [N_WAY-1:0]       way_valid_i,
    input  logic                   kill_i,
    output logic                   l2_req_valid_o,
    input  logic                   l2_req_ready_i,
    output logic [TAG_W+IDX_W-1:0] l2_req_addr_o,
    input  logic                   l2_rsp_valid_i,
    input  logic [BEAT_WIDTH-1:0]  l2_rsp_data_i,
    output logic                   wr_en_o,
    output logic [N_WAY-1:0]       wr_way_o,
    output logic [IDX_W-1:0]       wr_idx_o,
    output logic [TAG_W-1:0]       wr_tag_o,
    output logic [LINE_WIDTH-1:0]  ifill_data_o,
    output logic                   ifill_valid_o,
`ifdef SARGANTANA_ICACHE_REFILL_PERF_EN
    output logic [31:0]            perf_refill_cnt_o,
    output logic [31:0]            perf_stall_cnt_o,
`endif
    output logic                   busy_o
);

    localparam int c_n_beats = LINE_WIDTH / BEAT_WIDTH;
    localparam int c_cnt_w   = (c_n_beats > 1) ? $clog2(c_n_beats) : 1;
    localparam int c_ptr_w   = (N_WAY > 1) ? $clog2(N_WAY) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FILL = 3'd3,
        S_KILL = 3'd4
    } state_t;

    state_t                r_state;
    logic [TAG_W-1:0]      r_tag;
    logic [IDX_W-1:0]      r_idx;
    logic [N_WAY-1:0]      r_victim;
    logic                  r_use_rr;
    logic [c_ptr_w-1:0]    r_rr_ptr;
    logic [c_cnt_w-1:0]    r_beat_cnt;
    logic [LINE_WIDTH-1:0] r_line;

    logic                  w_any_invalid;
    logic [N_WAY-1:0]      w_free_way;
    logic [N_WAY-1:0]      w_rr_way;
    logic                  w_last_beat;

    // Scan downwards so the lowest invalid way is the one that sticks.
    always_comb begin
        w_any_invalid = 1'b0;
        w_free_way    = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!way_valid_i[i]) begin
                w_any_invalid = 1'b1;
                w_free_way    = '0;
                w_free_way[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rr_way           = '0;
        w_rr_way[r_rr_ptr] = 1'b1;
    end

    assign w_last_beat   = (r_beat_cnt == c_cnt_w'(c_n_beats - 1));
    assign l2_req_addr_o = {r_tag, r_idx};
    assign wr_tag_o      = r_tag;
    assign wr_idx_o      = r_idx;
    assign ifill_data_o  = r_line;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_tag          <= '0;
            r_idx          <= '0;
            r_victim       <= '0;
            r_use_rr       <= 1'b0;
            r_rr_ptr       <= '0;
            r_beat_cnt     <= '0;
            r_line         <= '0;
            l2_req_valid_o <= 1'b0;
            wr_en_o        <= 1'b0;
            ifill_valid_o  <= 1'b0;
            wr_way_o       <= '0;
            busy_o         <= 1'b0;
        end else begin
            wr_en_o       <= 1'b0;
            ifill_valid_o <= 1'b0;
            wr_way_o      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (miss_i && !kill_i) begin
                        r_state        <= S_REQ;
                        l2_req_valid_o <= 1'b1;
                        busy_o         <= 1'b1;
                        r_tag          <= miss_tag_i;
                        r_idx          <= miss_idx_i;
                        r_victim       <= w_any_invalid ? w_free_way : w_rr_way;
                        r_use_rr       <= !w_any_invalid;
                    end
                end
                S_REQ: begin
                    // A handshake in the kill cycle still owes us beats to drain.
                    if (l2_req_ready_i) begin
                        l2_req_valid_o <= 1'b0;
                        r_state        <= kill_i ? S_KILL : S_WAIT;
                    end else if (kill_i) begin
                        l2_req_valid_o <= 1'b0;
                        busy_o         <= 1'b0;
                        r_state        <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (l2_rsp_valid_i) begin
                        for (int k = 0; k < c_n_beats; k++) begin
                            if (r_beat_cnt == c_cnt_w'(k)) begin
                                r_line[k*BEAT_WIDTH +: BEAT_WIDTH] <= l2_rsp_data_i;
                            end
                        end
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            if (kill_i) begin
                                r_state <= S_IDLE;
                                busy_o  <= 1'b0;
                            end else begin
                                r_state       <= S_FILL;
                                wr_en_o       <= 1'b1;
                                ifill_valid_o <= 1'b1;
                                wr_way_o      <= r_victim;
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                            if (kill_i) begin
                                r_state <= S_KILL;
                            end
                        end
                    end else if (kill_i) begin
                        r_state <= S_KILL;
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                    if (r_use_rr) begin
                        r_rr_ptr <= r_rr_ptr + 1'b1;
                    end
                end
                S_KILL: begin
                    if (l2_rsp_valid_i) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            r_state    <= S_IDLE;
                            busy_o     <= 1'b0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    l2_req_valid_o <= 1'b0;
                    busy_o         <= 1'b0;
                end
            endcase
        end
    end

`ifdef SARGANTANA_ICACHE_REFILL_PERF_EN
    logic [31:0] r_refill_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_refill_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if ((r_state == S_FILL) && (r_refill_cnt != 32'hFFFF_FFFF)) begin
                r_refill_cnt <= r_refill_cnt + 32'd1;
            end
            if (busy_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign perf_refill_cnt_o = r_refill_cnt;
    assign perf_stall_cnt_o  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sargantana_icache_refill_unit.sv
// ============================================================================
//  Module      : tb_sargantana_icache_refill_unit
//  Description : Directed self-checking bench for the icache refill unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sargantana_icache_refill_unit;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         miss_i;
    logic [19:0]  miss_tag_i;
    logic [5:0]   miss_idx_i;
    logic [3:0]   way_valid_i;
    logic         kill_i;
    logic         l2_req_valid_o;
    logic         l2_req_ready_i;
    logic [25:0]  l2_req_addr_o;
    logic         l2_rsp_valid_i;
    logic [127:0] l2_rsp_data_i;
    logic         wr_en_o;
    logic [3:0]   wr_way_o;
    logic [5:0]   wr_idx_o;
    logic [19:0]  wr_tag_o;
    logic [255:0] ifill_data_o;
    logic         ifill_valid_o;
    logic         busy_o;
`ifdef SARGANTANA_ICACHE_REFILL_PERF_EN
    logic [31:0]  perf_refill_cnt_o;
    logic [31:0]  perf_stall_cnt_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk_i = ~clk_i;

    sargantana_icache_refill_unit dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .miss_i         (miss_i),
        .miss_tag_i     (miss_tag_i),
        .miss_idx_i     (miss_idx_i),
        .way_valid_i    (way_valid_i),
        .kill_i         (kill_i),
        .l2_req_valid_o (l2_req_valid_o),
        .l2_req_ready_i (l2_req_ready_i),
        .l2_req_addr_o  (l2_req_addr_o),
        .l2_rsp_valid_i (l2_rsp_valid_i),
        .l2_rsp_data_i  (l2_rsp_data_i),
        .wr_en_o        (wr_en_o),
        .wr_way_o       (wr_way_o),
        .wr_idx_o       (wr_idx_o),
        .wr_tag_o       (wr_tag_o),
        .ifill_data_o   (ifill_data_o),
        .ifill_valid_o  (ifill_valid_o),
`ifdef SARGANTANA_ICACHE_REFILL_PERF_EN
        .perf_refill_cnt_o (perf_refill_cnt_o),
        .perf_stall_cnt_o  (perf_stall_cnt_o),
`endif
        .busy_o         (busy_o)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_valid"}, 256'(l2_req_valid_o), 256'd0);
        chk({tag, "_req_addr"},  256'(l2_req_addr_o),  256'd0);
        chk({tag, "_wr_en"},     256'(wr_en_o),        256'd0);
        chk({tag, "_wr_way"},    256'(wr_way_o),       256'd0);
        chk({tag, "_ifill_vld"}, 256'(ifill_valid_o),  256'd0);
        chk({tag, "_ifill_dat"}, ifill_data_o,         256'd0);
        chk({tag, "_busy"},      256'(busy_o),         256'd0);
    endtask

    // Full refill with immediate ready and back-to-back beats.
    task automatic refill(input logic [19:0] tag, input logic [5:0] idx, input logic [3:0] vv,
                          input logic [127:0] b0, input logic [127:0] b1,
                          input logic [3:0] exp_way);
        miss_i = 1'b1; miss_tag_i = tag; miss_idx_i = idx; way_valid_i = vv;
        l2_req_ready_i = 1'b1;
        tick();
        miss_i = 1'b0; way_valid_i = 4'h0; miss_tag_i = '0; miss_idx_i = '0;
        chk("rf_req_valid", 256'(l2_req_valid_o), 256'd1);
        chk("rf_req_addr",  256'(l2_req_addr_o),  256'({tag, idx}));
        chk("rf_busy_req",  256'(busy_o),         256'd1);
        tick();
        chk("rf_req_drop",  256'(l2_req_valid_o), 256'd0);
        l2_rsp_valid_i = 1'b1; l2_rsp_data_i = b0;
        tick();
        chk("rf_no_early_wr", 256'(wr_en_o), 256'd0);
        l2_rsp_data_i = b1;
        tick();
        l2_rsp_valid_i = 1'b0; l2_rsp_data_i = '0;
        chk("rf_wr_en",    256'(wr_en_o),       256'd1);
        chk("rf_ifill_v",  256'(ifill_valid_o), 256'd1);
        chk("rf_wr_way",   256'(wr_way_o),      256'(exp_way));
        chk("rf_line",     ifill_data_o,        {b1, b0});
        chk("rf_wr_tag",   256'(wr_tag_o),      256'(tag));
        chk("rf_wr_idx",   256'(wr_idx_o),      256'(idx));
        tick();
        chk("rf_wr_en_off", 256'(wr_en_o), 256'd0);
        chk("rf_busy_off",  256'(busy_o),  256'd0);
    endtask

    initial begin
        rst_i = 1'b1; miss_i = 1'b0; miss_tag_i = '0; miss_idx_i = '0;
        way_valid_i = '0; kill_i = 1'b0; l2_req_ready_i = 1'b0;
        l2_rsp_valid_i = 1'b0; l2_rsp_data_i = '0;
        tick(); tick();
        chk_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // Basic refill: ways 0,1 valid -> way 2 is the lowest invalid.
        refill(20'h12345, 6'd5, 4'b0011, {4{32'hAAAA_0001}}, {4{32'hBBBB_0002}}, 4'b0100);

        // Ready held low for 10 cycles with a spurious beat on the bus.
        miss_i = 1'b1; miss_tag_i = 20'hABCDE; miss_idx_i = 6'd63; way_valid_i = 4'b0000;
        l2_req_ready_i = 1'b0;
        tick();
        miss_i = 1'b0; miss_tag_i = '0; miss_idx_i = '0;
        l2_rsp_valid_i = 1'b1; l2_rsp_data_i = {4{32'hDEAD_BEEF}};
        for (int i = 0; i < 10; i++) begin
            chk("stall_req_valid", 256'(l2_req_valid_o), 256'd1);
            chk("stall_req_addr",  256'(l2_req_addr_o),  256'({20'hABCDE, 6'd63}));
            tick();
        end
        l2_req_ready_i = 1'b1; l2_rsp_valid_i = 1'b0;
        tick();
        chk("stall_req_drop", 256'(l2_req_valid_o), 256'd0);
        l2_rsp_valid_i = 1'b1; l2_rsp_data_i = {4{32'hCCCC_0003}};
        tick();
        chk("stall_no_early_wr", 256'(wr_en_o), 256'd0);
        l2_rsp_data_i = {4{32'hDDDD_0004}};
        tick();
        l2_rsp_valid_i = 1'b0;
        chk("stall_wr_en", 256'(wr_en_o), 256'd1);
        chk("stall_way",   256'(wr_way_o), 256'(4'b0001));
        chk("stall_line",  ifill_data_o, {{4{32'hDDDD_0004}}, {4{32'hCCCC_0003}}});
        tick();

        // Full set: round-robin victims 0,1,2,3,0.
        refill(20'h00001, 6'd1, 4'hF, 128'h1, 128'h2, 4'b0001);
        refill(20'h00002, 6'd2, 4'hF, 128'h3, 128'h4, 4'b0010);
        refill(20'h00003, 6'd3, 4'hF, 128'h5, 128'h6, 4'b0100);
        refill(20'h00004, 6'd4, 4'hF, 128'h7, 128'h8, 4'b1000);
        refill(20'h00005, 6'd5, 4'hF, 128'h9, 128'hA, 4'b0001);

        // Kill one cycle after the handshake: both beats drained, no write.
        miss_i = 1'b1; miss_tag_i = 20'h0BEEF; miss_idx_i = 6'd9; way_valid_i = 4'hF;
        l2_req_ready_i = 1'b1;
        tick();
        miss_i = 1'b0;
        tick();
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kill_busy_hold", 256'(busy_o),  256'd1);
        chk("kill_no_wr0",    256'(wr_en_o), 256'd0);
        l2_rsp_valid_i = 1'b1; l2_rsp_data_i = {4{32'h5555_5555}};
        tick();
        chk("kill_busy_beat0", 256'(busy_o),  256'd1);
        chk("kill_no_wr1",     256'(wr_en_o), 256'd0);
        tick();
        l2_rsp_valid_i = 1'b0;
        chk("kill_busy_fall", 256'(busy_o),  256'd0);
        chk("kill_no_wr2",    256'(wr_en_o), 256'd0);
        tick();
        chk("kill_no_wr3", 256'(wr_en_o),       256'd0);
        chk("kill_no_fill", 256'(ifill_valid_o), 256'd0);

        // Kill while the request is still pending: request withdrawn.
        l2_req_ready_i = 1'b0;
        miss_i = 1'b1; miss_tag_i = 20'h00077; miss_idx_i = 6'd7;
        tick();
        miss_i = 1'b0; kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        chk("kreq_req_valid", 256'(l2_req_valid_o), 256'd0);
        chk("kreq_busy",      256'(busy_o),         256'd0);

        // Kill together with a miss in IDLE: miss ignored.
        miss_i = 1'b1; kill_i = 1'b1;
        tick();
        miss_i = 1'b0; kill_i = 1'b0;
        chk("kmiss_req_valid", 256'(l2_req_valid_o), 256'd0);
        chk("kmiss_busy",      256'(busy_o),         256'd0);

        // Killed refills must not advance the round-robin pointer.
        refill(20'h00010, 6'd10, 4'hF, 128'hB, 128'hC, 4'b0010);

        // Reset in WAIT after the first beat, then a clean refill.
        miss_i = 1'b1; miss_tag_i = 20'h00020; miss_idx_i = 6'd20; way_valid_i = 4'b0001;
        l2_req_ready_i = 1'b1;
        tick();
        miss_i = 1'b0;
        tick();
        l2_rsp_valid_i = 1'b1; l2_rsp_data_i = {4{32'h7777_7777}};
        tick();
        l2_rsp_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        chk_all_zero("midrst");
        rst_i = 1'b0;
        tick();
        refill(20'h00030, 6'd30, 4'hF, {4{32'hEEEE_0005}}, {4{32'hFFFF_0006}}, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
